cp0_regfile: RTL and testbench

Coprocessor-0 register file that records exceptions on behalf of the pipeline and raises interrupt requests into it. Accepts the committed exception code and faulting PC from the memory stage. Updates EPC/Cause/Status accordingly and supplies EPC back to the exception redirect logic for ERET. Also owns the Count/Compare timer, samples hardware interrupts and serves MFC0/MTC0 accesses.

---
 rtl/cp0_regfile_if.sv | 32 +++
 rtl/cp0_regfile.sv | 128 ++++++++++++
 tb/tb_cp0_regfile.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_if.sv
// CP0 access bundle between the pipeline and the coprocessor-0 register file.
// Carries exception commit, MTC0/MFC0 access, interrupt lines and status/redirect outputs.
interface cp0_regfile_if #(
   parameter int DATA_WIDTH = 32
);
   logic [2:0]            exception;
   logic [DATA_WIDTH-1:0] except_pc;
   logic                  except_in_delay_slot;
   logic                  we;
   logic [4:0]            waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [4:0]            raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic [5:0]            hw_int;
   logic                  interrupt_req;
   logic [DATA_WIDTH-1:0] epc;
   logic [DATA_WIDTH-1:0] status;
   logic [DATA_WIDTH-1:0] cause;
   logic                  timer_int;

   modport master (
      output exception, except_pc, except_in_delay_slot,
      output we, waddr, wdata, raddr, hw_int,
      input  rdata, interrupt_req, epc, status, cause, timer_int
   );

   modport slave (
      input  exception, except_pc, except_in_delay_slot,
      input  we, waddr, wdata, raddr, hw_int,
      output rdata, interrupt_req, epc, status, cause, timer_int
   );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC.
// Ports: clk, rst (async active-high), bus (cp0_regfile_if.slave).
module cp0_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_HW_INT = 6
) (
   input logic        clk,
   input logic        rst,
   cp0_regfile_if.slave bus
);

   localparam logic [4:0] R_COUNT   = 5'd9;
   localparam logic [4:0] R_COMPARE = 5'd11;
   localparam logic [4:0] R_STATUS  = 5'd12;
   localparam logic [4:0] R_CAUSE   = 5'd13;
   localparam logic [4:0] R_EPC     = 5'd14;

   localparam logic [DATA_WIDTH-1:0] ST_MASK =
      DATA_WIDTH'(32'h0000_FF03);
   localparam logic [DATA_WIDTH-1:0] CA_MASK =
      DATA_WIDTH'(32'h0000_0300);

   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] compare_q, compare_d;
   logic [DATA_WIDTH-1:0] status_q, status_d;
   logic [DATA_WIDTH-1:0] cause_q, cause_d;
   logic [DATA_WIDTH-1:0] epc_q, epc_d;
   logic                  timer_q, timer_d;

   logic       exc_take;
   logic       eret;
   logic [4:0] exc_code;
   logic       wr_count, wr_cmp, wr_st, wr_ca, wr_epc;
   logic       fwd;

   always_comb begin
      exc_take = 1'b0;
      eret     = 1'b0;
      exc_code = 5'd0;
      case (bus.exception)
         3'd1: begin exc_take = 1'b1; exc_code = 5'd0;  end
         3'd2: begin exc_take = 1'b1; exc_code = 5'd8;  end
         3'd3: begin exc_take = 1'b1; exc_code = 5'd10; end
         3'd4: begin exc_take = 1'b1; exc_code = 5'd13; end
         3'd5: begin exc_take = 1'b1; exc_code = 5'd12; end
         3'd6: eret = 1'b1;
         default: ;
      endcase
   end

   assign wr_count = bus.we & (bus.waddr == R_COUNT);
   assign wr_cmp   = bus.we & (bus.waddr == R_COMPARE);
   assign wr_st    = bus.we & (bus.waddr == R_STATUS);
   assign wr_ca    = bus.we & (bus.waddr == R_CAUSE);
   assign wr_epc   = bus.we & (bus.waddr == R_EPC);

   always_comb begin
      count_d   = wr_count ? bus.wdata : count_q + 1'b1;
      compare_d = wr_cmp ? bus.wdata : compare_q;
      // Compare write clears the flag even if a match lands that cycle
      timer_d   = ~wr_cmp &
                  (timer_q | ((count_q == compare_q) &
                              (compare_q != '0)));
      status_d  = status_q;
      cause_d   = cause_q;
      epc_d     = epc_q;
      cause_d[15:10] = {bus.hw_int[5] | timer_q, bus.hw_int[4:0]};
      // Exception/ERET own Status/Cause/EPC; a same-cycle MTC0 is dropped
      if (exc_take) begin
         if (!status_q[1]) begin
            epc_d = bus.except_in_delay_slot ?
                    bus.except_pc - DATA_WIDTH'(4) :
                    bus.except_pc;
            cause_d[31] = bus.except_in_delay_slot;
         end
         status_d[1]  = 1'b1;
         cause_d[6:2] = exc_code;
      end else if (eret) begin
         status_d[1] = 1'b0;
      end else begin
         if (wr_st)  status_d = bus.wdata & ST_MASK;
         if (wr_ca)  cause_d[9:8] = bus.wdata[9:8];
         if (wr_epc) epc_d = bus.wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         compare_q <= '0;
         status_q  <= '0;
         cause_q   <= '0;
         epc_q     <= '0;
         timer_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         status_q  <= status_d;
         cause_q   <= cause_d;
         epc_q     <= epc_d;
         timer_q   <= timer_d;
      end
   end

   assign fwd = bus.we & (bus.waddr == bus.raddr);

   always_comb begin
      bus.rdata = '0;
      case (bus.raddr)
         R_COUNT:   bus.rdata = fwd ? bus.wdata : count_q;
         R_COMPARE: bus.rdata = fwd ? bus.wdata : compare_q;
         R_STATUS:  bus.rdata = fwd ? (bus.wdata & ST_MASK) : status_q;
         R_CAUSE:   bus.rdata = fwd ?
                       ((cause_q & ~CA_MASK) | (bus.wdata & CA_MASK)) :
                       cause_q;
         R_EPC:     bus.rdata = fwd ? bus.wdata : epc_q;
         default:   bus.rdata = '0;
      endcase
   end

   assign bus.epc           = wr_epc ? bus.wdata : epc_q;
   assign bus.status        = status_q;
   assign bus.cause         = cause_q;
   assign bus.timer_int     = timer_q;
   assign bus.interrupt_req = status_q[0] & ~status_q[1] &
                              (|(cause_q[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized and directed bench for cp0_regfile against a field-level model.
// Ports: none (top-level testbench).
module tb_cp0_regfile;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   cp0_regfile_if #(.DATA_WIDTH(32)) bus ();

   cp0_regfile #(.DATA_WIDTH(32), .NUM_HW_INT(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // model state, kept as separate architectural fields
   bit [31:0] m_count, m_compare, m_epc;
   bit        m_ie, m_exl, m_bd, m_timer;
   bit [7:0]  m_im, m_ip;
   bit [4:0]  m_code;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] m_status();
      return {16'h0, m_im, 6'h0, m_exl, m_ie};
   endfunction

   function automatic bit [31:0] m_cause();
      return {m_bd, 15'h0, m_ip, 1'b0, m_code, 2'b00};
   endfunction

   task automatic m_reset();
      m_count = 0; m_compare = 0; m_epc = 0;
      m_ie = 0; m_exl = 0; m_bd = 0; m_timer = 0;
      m_im = 0; m_ip = 0; m_code = 0;
   endtask

   function automatic bit [31:0] exp_rdata();
      bit [31:0] v;
      bit        f;
      f = bus.we && (bus.waddr == bus.raddr);
      case (bus.raddr)
         9:  v = f ? bus.wdata : m_count;
         11: v = f ? bus.wdata : m_compare;
         12: v = f ? (bus.wdata & 32'hFF03) : m_status();
         13: v = f ? ((m_cause() & ~32'h300) | (bus.wdata & 32'h300))
                   : m_cause();
         14: v = f ? bus.wdata : m_epc;
         default: v = 0;
      endcase
      return v;
   endfunction

   // advance the model by one clock with the inputs currently applied
   task automatic m_step();
      int  e;
      bit  exc, eret, w;
      bit  hit;
      e    = int'(bus.exception);
      exc  = (e >= 1 && e <= 5);
      eret = (e == 6);
      w    = bus.we;
      hit  = (m_count == m_compare) && (m_compare != 0);
      m_ip[7:2] = {bus.hw_int[5] | m_timer, bus.hw_int[4:0]};
      m_timer = (m_timer || hit) && !(w && bus.waddr == 11);
      if (w && bus.waddr == 9) m_count = bus.wdata;
      else m_count = m_count + 1;
      if (w && bus.waddr == 11) m_compare = bus.wdata;
      if (exc) begin
         if (!m_exl) begin
            m_epc = bus.except_pc - (bus.except_in_delay_slot ? 4 : 0);
            m_bd  = bus.except_in_delay_slot;
         end
         m_exl = 1;
         case (e)
            1: m_code = 0;
            2: m_code = 8;
            3: m_code = 10;
            4: m_code = 13;
            default: m_code = 12;
         endcase
      end else if (eret) begin
         m_exl = 0;
      end else if (w) begin
         if (bus.waddr == 12) begin
            m_ie  = bus.wdata[0];
            m_exl = bus.wdata[1];
            m_im  = bus.wdata[15:8];
         end
         if (bus.waddr == 13) m_ip[1:0] = bus.wdata[9:8];
         if (bus.waddr == 14) m_epc = bus.wdata;
      end
   endtask

   // compare all outputs mid-cycle, then clock once
   task automatic step();
      #1;
      chk("rdata", bus.rdata, exp_rdata());
      chk("epc", bus.epc,
          (bus.we && bus.waddr == 14) ? bus.wdata : m_epc);
      chk("status", bus.status, m_status());
      chk("cause", bus.cause, m_cause());
      chk("int_req", 32'(bus.interrupt_req),
          32'(m_ie & ~m_exl & (|(m_ip & m_im))));
      chk("timer", 32'(bus.timer_int), 32'(m_timer));
      @(posedge clk);
      m_step();
      @(negedge clk);
   endtask

   task automatic set_in(int e, bit [31:0] pc, bit ds, bit w,
                         bit [4:0] wa, bit [31:0] wd, bit [4:0] ra,
                         bit [5:0] hw);
      bus.exception            = 3'(e);
      bus.except_pc            = pc;
      bus.except_in_delay_slot = ds;
      bus.we                   = w;
      bus.waddr                = wa;
      bus.wdata                = wd;
      bus.raddr                = ra;
      bus.hw_int               = hw;
   endtask

   task automatic idle(bit [4:0] ra, bit [5:0] hw);
      set_in(0, 0, 0, 0, 0, 0, ra, hw);
   endtask

   task automatic mtc0(bit [4:0] wa, bit [31:0] wd);
      set_in(0, 0, 0, 1, wa, wd, 0, 0);
      step();
   endtask

   initial begin
      bit [4:0] addrs [5] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
      int guard;
      m_reset();
      idle(12, 0);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_status", bus.status, 32'h0);
      chk("rst_req", 32'(bus.interrupt_req), 32'h0);
      rst = 1'b0;
      step();

      mtc0(12, 32'hFFFF_FFFF);
      idle(12, 0); #1;
      chk("st_mask", bus.rdata, 32'h0000_FF03);
      step();
      mtc0(13, 32'hFFFF_FFFF);
      idle(13, 0); #1;
      chk("ca_mask", bus.rdata, 32'h0000_0300);
      step();
      mtc0(12, 0);

      set_in(2, 32'h1000, 0, 0, 0, 0, 14, 0); step();
      idle(14, 0); #1;
      chk("sys_epc", bus.rdata, 32'h1000);
      chk("sys_code", bus.cause & 32'h8000_007C, 32'h20);
      chk("sys_exl", bus.status & 32'h2, 32'h2);
      step();
      set_in(5, 32'h2000, 0, 0, 0, 0, 14, 0); step();
      idle(14, 0); #1;
      chk("ovf_epc", bus.epc, 32'h1000);
      chk("ovf_code", bus.cause & 32'h7C, 32'h30);
      step();
      set_in(6, 0, 0, 0, 0, 0, 12, 0); step();
      idle(12, 0); #1;
      chk("eret_exl", bus.status & 32'h2, 32'h0);
      step();

      set_in(3, 32'h3004, 1, 0, 0, 0, 14, 0); step();
      idle(14, 0); #1;
      chk("ds_epc", bus.epc, 32'h3000);
      chk("ds_cause", bus.cause & 32'h8000_007C, 32'h8000_0028);
      step();
      set_in(6, 0, 0, 0, 0, 0, 0, 0); step();

      mtc0(9, 10);
      mtc0(11, 20);
      mtc0(12, 32'h8001);
      guard = 0;
      idle(9, 0);
      while (m_count != 20 && guard < 100) begin
         step(); guard++;
      end
      chk("cnt_reach", 32'(guard < 100), 32'h1);
      #1;
      chk("tmr_pre", bus.rdata, 32'd20);
      chk("tmr_lo", 32'(bus.timer_int), 32'h0);
      step();
      #1;
      chk("tmr_hi", 32'(bus.timer_int), 32'h1);
      step();
      #1;
      chk("tmr_ip7", bus.cause & 32'h8000, 32'h8000);
      chk("tmr_req", 32'(bus.interrupt_req), 32'h1);
      step();
      mtc0(11, 0);
      idle(0, 0); #1;
      chk("tmr_clr", 32'(bus.timer_int), 32'h0);
      step();

      mtc0(9, 32'hFFFF_FFFF);
      idle(9, 0); #1;
      chk("wrap_hi", bus.rdata, 32'hFFFF_FFFF);
      step();
      #1;
      chk("wrap_lo", bus.rdata, 32'h0);
      step();

      mtc0(12, 32'h1001);
      idle(0, 6'h04); #1;
      chk("hw_lat0", 32'(bus.interrupt_req), 32'h0);
      step();
      #1;
      chk("hw_req", 32'(bus.interrupt_req), 32'h1);
      step();
      set_in(0, 0, 0, 1, 12, 32'h1003, 0, 6'h04); step();
      idle(0, 6'h04); #1;
      chk("hw_exl", 32'(bus.interrupt_req), 32'h0);
      step();
      set_in(0, 0, 0, 1, 12, 0, 0, 0); step();

      set_in(4, 32'h6000, 0, 1, 14, 32'h5000, 14, 0); step();
      idle(14, 0); #1;
      chk("prio_epc", bus.epc, 32'h6000);
      step();
      set_in(6, 0, 0, 1, 14, 32'h7000, 14, 0); #1;
      chk("fwd_epc", bus.epc, 32'h7000);
      step();

      for (int i = 0; i < 400; i++) begin
         int       e;
         bit [4:0] wa;
         bit [31:0] wd;
         e  = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 7);
         wa = ($urandom_range(0, 3) != 0) ? addrs[$urandom_range(0, 4)]
                                          : 5'($urandom);
         wd = $urandom;
         if (wa == 11 && $urandom_range(0, 1) == 1)
            wd = m_count + $urandom_range(1, 6);
         set_in(e, $urandom, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                wa, wd, ($urandom_range(0, 3) != 0) ?
                addrs[$urandom_range(0, 4)] : 5'($urandom),
                6'($urandom));
         if (i == 200) begin
            bus.we = 1'b0;
            rst = 1'b1;
            #1;
            chk("arst_st", bus.status, 32'h0);
            chk("arst_ca", bus.cause, 32'h0);
            chk("arst_tmr", 32'(bus.timer_int), 32'h0);
            m_reset();
            #1;
            rst = 1'b0;
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
